// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and uart_tx side signals of uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int MAX_BYTES = 4
);
  logic [1:0]             req_valid;
  logic [8*MAX_BYTES-1:0] req_payload0;
  logic [8*MAX_BYTES-1:0] req_payload1;
  logic [2:0]             req_len0;
  logic [2:0]             req_len1;
  logic [1:0]             req_ready;
  logic [1:0]             frame_done;
  logic [7:0]             tx_data;
  logic                   tx_data_ready;
  logic                   tx_done;
  logic                   busy;
  logic                   grant_id;

  modport slave (
    input  req_valid, req_payload0, req_payload1, req_len0, req_len1, tx_done,
    output req_ready, frame_done, tx_data, tx_data_ready, busy, grant_id
  );

  modport master (
    output req_valid, req_payload0, req_payload1, req_len0, req_len1, tx_done,
    input  req_ready, frame_done, tx_data, tx_data_ready, busy, grant_id
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - frame-atomic two-source arbiter for one uart_tx; UART_TX_ARBITER_FIXED_PRIO_EN selects fixed priority
module uart_tx_arbiter #(
  parameter int MAX_BYTES = 4
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);
  localparam int         PW      = 8 * MAX_BYTES;
  localparam logic [2:0] MAX_LEN = 3'(MAX_BYTES);

  typedef enum logic [1:0] {IDLE, START, GUARD, WAIT} state_t;

  state_t          state;
  logic [PW-1:0]   payload_q;
  logic [2:0]      len_q;
  logic [2:0]      idx;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
  logic            last_grant;
`endif
  logic [1:0]      frame_done_q;
  logic [7:0]      tx_data_q;
  logic            tx_start_q;
  logic            busy_q;
  logic            grant_q;

  logic            win;
  logic            accept;
  logic [1:0]      ready_c;
  logic [PW-1:0]   sel_payload;
  logic [2:0]      sel_len;
  logic [2:0]      clamped_len;
  logic [7:0]      next_byte;

  always_comb begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
    win = ~bus.req_valid[0];
`else
    if (&bus.req_valid) win = ~last_grant;
    else                win = ~bus.req_valid[0];
`endif
    accept  = (state == IDLE) && (|bus.req_valid) && !rst;
    ready_c = 2'b00;
    if (accept) ready_c[win] = 1'b1;
    sel_payload = win ? bus.req_payload1 : bus.req_payload0;
    sel_len     = win ? bus.req_len1 : bus.req_len0;
    clamped_len = (sel_len > MAX_LEN) ? MAX_LEN : sel_len;
    next_byte   = 8'(payload_q >> {idx + 3'd1, 3'b000});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      payload_q    <= '0;
      len_q        <= 3'd0;
      idx          <= 3'd0;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
      last_grant   <= 1'b1;
`endif
      frame_done_q <= 2'b00;
      tx_data_q    <= 8'h00;
      tx_start_q   <= 1'b0;
      busy_q       <= 1'b0;
      grant_q      <= 1'b0;
    end else begin
      frame_done_q <= 2'b00;
      tx_start_q   <= 1'b0;
      case (state)
        IDLE: begin
          // busy lingers through the frame_done cycle, then drops here unless a new frame lands
          busy_q <= accept;
          if (accept) begin
            grant_q   <= win;
`ifndef UART_TX_ARBITER_FIXED_PRIO_EN
            last_grant <= win;
`endif
            payload_q <= sel_payload;
            len_q     <= clamped_len;
            idx       <= 3'd0;
            if (clamped_len == 3'd0) begin
              frame_done_q[win] <= 1'b1;
            end else begin
              tx_data_q  <= sel_payload[7:0];
              tx_start_q <= 1'b1;
              state      <= START;
            end
          end
        end
        START: state <= GUARD;
        GUARD: state <= WAIT;
        WAIT: begin
          if (bus.tx_done) begin
            if (idx == len_q - 3'd1) begin
              frame_done_q[grant_q] <= 1'b1;
              state                 <= IDLE;
            end else begin
              idx        <= idx + 3'd1;
              tx_data_q  <= next_byte;
              tx_start_q <= 1'b1;
              state      <= START;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.frame_done    = frame_done_q;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_ready = tx_start_q;
  assign bus.busy          = busy_q;
  assign bus.grant_id      = grant_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - randomized self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.MAX_BYTES(MB)) bus ();
  uart_tx_arbiter #(.MAX_BYTES(MB)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  logic [8:0] rx_q[$];
  logic [8:0] exp_q[$];
  int         starts = 0;
  int         fd_cnt[2] = '{0, 0};
  int         exp_fd[2] = '{0, 0};
  int         uart_cnt = 0;
  bit         model_last = 1'b1;

  // uart_tx stand-in: captures each started byte, holds done low for a random time
  always @(negedge clk) begin
    if (bus.tx_data_ready === 1'b1) begin
      rx_q.push_back({bus.grant_id, bus.tx_data});
      starts++;
      bus.tx_done = 1'b0;
      uart_cnt = $urandom_range(6, 2);
    end else if (uart_cnt > 0) begin
      uart_cnt--;
      if (uart_cnt == 0) bus.tx_done = 1'b1;
    end else begin
      bus.tx_done = 1'b1;
    end
    if (bus.frame_done[0] === 1'b1) fd_cnt[0]++;
    if (bus.frame_done[1] === 1'b1) fd_cnt[1]++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  function automatic bit model_pick(input bit [1:0] pend);
    if (pend == 2'b11) begin
`ifdef UART_TX_ARBITER_FIXED_PRIO_EN
      return 1'b0;
`else
      return ~model_last;
`endif
    end
    return (pend == 2'b10);
  endfunction

  task automatic push_frame(input bit id, input logic [31:0] p, input logic [2:0] len);
    int n;
    n = (int'(len) > MB) ? MB : int'(len);
    for (int k = 0; k < n; k++) exp_q.push_back({id, p[k*8 +: 8]});
    exp_fd[id]++;
  endtask

  task automatic offer(input bit [1:0] mask, input logic [31:0] p0, input logic [31:0] p1,
                       input logic [2:0] l0, input logic [2:0] l1);
    bit [1:0]    pend;
    bit [1:0]    acc;
    bit          exp_id;
    logic [31:0] pp[2];
    logic [2:0]  ll[2];
    int          budget;
    pp[0] = p0; pp[1] = p1; ll[0] = l0; ll[1] = l1;
    if (mask[0]) begin bus.req_payload0 = p0; bus.req_len0 = l0; end
    if (mask[1]) begin bus.req_payload1 = p1; bus.req_len1 = l1; end
    bus.req_valid = mask;
    pend = mask;
    acc = 2'b00;
    budget = 0;
    while (pend != 2'b00 && budget < 2000) begin
      #1;
      for (int i = 0; i < 2; i++)
        if (pend[i] && bus.req_ready[i] === 1'b1) acc[i] = 1'b1;
      if (acc != 2'b00) begin
        exp_id = model_pick(pend);
        checks++;
        if (acc !== (2'b01 << exp_id)) begin
          errors++;
          $display("FAIL grant_order: ready %b required %b", acc, 2'b01 << exp_id);
        end
      end
      @(negedge clk);
      budget++;
      for (int i = 0; i < 2; i++) begin
        if (acc[i]) begin
          bus.req_valid[i] = 1'b0;
          pend[i] = 1'b0;
          acc[i] = 1'b0;
          model_last = i[0];
          push_frame(i[0], pp[i], ll[i]);
          checks++;
          if (bus.busy !== 1'b1) begin errors++; $display("FAIL busy_after_accept: got %b required 1", bus.busy); end
          checks++;
          if (bus.grant_id !== i[0]) begin errors++; $display("FAIL grant_id: got %b required %0d", bus.grant_id, i); end
          if (ll[i] == 3'd0) begin
            checks++;
            if (bus.frame_done[i] !== 1'b1 || bus.tx_data_ready !== 1'b0) begin
              errors++;
              $display("FAIL len0_done: frame_done %b tx_data_ready %b required done[%0d]=1 start=0", bus.frame_done, bus.tx_data_ready, i);
            end
          end else begin
            checks++;
            if (bus.tx_data_ready !== 1'b1 || bus.tx_data !== pp[i][7:0]) begin
              errors++;
              $display("FAIL first_byte: start %b data %h required start 1 data %h", bus.tx_data_ready, bus.tx_data, pp[i][7:0]);
            end
          end
        end
      end
    end
    if (pend != 2'b00) begin
      checks++; errors++;
      $display("FAIL accept_timeout: pending %b required 00", pend);
      bus.req_valid = 2'b00;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(bus.busy === 1'b0 && bus.tx_done === 1'b1) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (n >= 3000) begin
      checks++; errors++;
      $display("FAIL idle_timeout: busy %b tx_done %b required 0/1", bus.busy, bus.tx_done);
    end
  endtask

  task automatic compare_rx(input string name);
    int n;
    checks++;
    if (rx_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s byte_count: got %0d required %0d", name, rx_q.size(), exp_q.size());
    end
    n = (rx_q.size() < exp_q.size()) ? rx_q.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      checks++;
      if (rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s byte%0d: got owner %b data %h required owner %b data %h", name, k, rx_q[k][8], rx_q[k][7:0], exp_q[k][8], exp_q[k][7:0]);
      end
    end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (fd_cnt[i] != exp_fd[i]) begin
        errors++;
        $display("FAIL %s frame_done%0d count: got %0d required %0d", name, i, fd_cnt[i], exp_fd[i]);
      end
    end
    rx_q.delete();
    exp_q.delete();
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (bus.req_ready !== 2'b00 || bus.frame_done !== 2'b00 || bus.tx_data !== 8'h00 ||
        bus.tx_data_ready !== 1'b0 || bus.busy !== 1'b0 || bus.grant_id !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready %b done %b data %h start %b busy %b grant %b required 00 00 00 0 0 0",
               name, bus.req_ready, bus.frame_done, bus.tx_data, bus.tx_data_ready, bus.busy, bus.grant_id);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req_payload0 = 32'h11223344; bus.req_len0 = 3'd3;
    bus.req_payload1 = 32'h55667788; bus.req_len1 = 3'd2;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset_state");
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b0;
    model_last = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (starts != 0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_accept: starts %0d busy %b required 0 0", starts, bus.busy);
    end
  endtask

  task automatic test_basic();
    offer(2'b01, 32'h00ABCDEF, 32'h0, 3'd3, 3'd0);
    wait_idle();
    compare_rx("basic");
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_low: got %b required 0", bus.busy); end
  endtask

  task automatic test_tie();
    offer(2'b11, 32'h0000AAAA, 32'h00000055, 3'd2, 3'd1);
    wait_idle();
    compare_rx("tie_first");
    offer(2'b11, $urandom, $urandom, 3'($urandom_range(4, 1)), 3'($urandom_range(4, 1)));
    wait_idle();
    compare_rx("tie_second");
  endtask

  task automatic test_mid_frame();
    offer(2'b01, 32'h89ABCDEF, 32'h0, 3'd4, 3'd0);
    repeat (4) @(negedge clk);
    offer(2'b10, 32'h0, $urandom, 3'd0, 3'($urandom_range(4, 1)));
    wait_idle();
    compare_rx("mid_frame");
  endtask

  task automatic test_len_edge();
    int s0;
    s0 = starts;
    offer(2'b01, $urandom, 32'h0, 3'd0, 3'd0);
    wait_idle();
    checks++;
    if (starts != s0) begin errors++; $display("FAIL len0_no_start: starts %0d required %0d", starts, s0); end
    compare_rx("len0");
    offer(2'b01, 32'hDEADBEEF, 32'h0, 3'd7, 3'd0);
    wait_idle();
    compare_rx("len7_clamp");
  endtask

  task automatic test_reset_mid();
    int base;
    int n = 0;
    base = starts;
    offer(2'b01, $urandom, 32'h0, 3'd4, 3'd0);
    while (starts < base + 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("reset_mid_outputs");
    rst = 1'b0;
    model_last = 1'b1;
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    exp_fd[0]--;
    repeat (60) @(negedge clk);
    checks++;
    if (starts != base + 2) begin errors++; $display("FAIL reset_mid_starts: got %0d required %0d", starts - base, 2); end
    compare_rx("reset_mid");
    wait_idle();
    offer(2'b01, 32'h00000001, 32'h0, 3'd1, 3'd0);
    wait_idle();
    compare_rx("after_reset");
  endtask

  task automatic test_payload_change();
    offer(2'b01, $urandom, 32'h0, 3'd4, 3'd0);
    bus.req_payload0 = $urandom;
    bus.req_len0 = 3'($urandom_range(7, 0));
    repeat (5) @(negedge clk);
    bus.req_payload0 = $urandom;
    wait_idle();
    compare_rx("payload_latched");
  endtask

  task automatic test_random();
    for (int t = 0; t < 30; t++) begin
      offer(2'($urandom_range(3, 1)), $urandom, $urandom,
            3'($urandom_range(7, 0)), 3'($urandom_range(7, 0)));
      wait_idle();
    end
    compare_rx("random");
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_payload0 = '0;
    bus.req_payload1 = '0;
    bus.req_len0 = 3'd0;
    bus.req_len1 = 3'd0;
    test_reset();
    test_basic();
    test_tie();
    test_mid_frame();
    test_len_edge();
    test_reset_mid();
    test_payload_change();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` serializer between two frame sources in the console-mux command path. Requester 0 carries command responses (pin map and enable mask readback); requester 1 carries unsolicited input-pin event reports. Each requester hands over a whole multi-byte frame, and the block sends it byte by byte, LSB first. Arbitration is frame-atomic, so bytes from different sources never interleave on the serial line.

## Interface
- `MAX_BYTES`, default 4: maximum bytes per frame. Payload width is 8*MAX_BYTES.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 2: per-requester frame valid.
- `req_payload0`, `req_payload1` in 8*MAX_BYTES: frame payload; byte 0 is bits [7:0].
- `req_len0`, `req_len1` in 3: byte count, 0..MAX_BYTES.
- `req_ready` out 2: frame accepted this cycle (transfer on valid&&ready).
- `frame_done` out 2: one-cycle pulse to the owner when its frame's last byte completes.
- `tx_data` out 8: byte to `uart_tx`.
- `tx_data_ready` out 1: one-cycle start pulse to `uart_tx`.
- `tx_done` in 1: `uart_tx` byte complete (level, high while idle).
- `busy` out 1: high from acceptance until the frame finishes.
- `grant_id` out 1: owner of the current or last frame.

## Operation
- States: IDLE, START, GUARD, WAIT.
- **IDLE**
  - `req_ready` is combinational: it asserts only for the arbitration winner, and only while in IDLE.
  - On acceptance, the block latches payload and len, sets idx=0, sets `grant_id`, and goes to START.
  - len 0: the frame is accepted, no byte is sent, `frame_done` pulses on the next cycle, and the state stays IDLE.
  - len > MAX_BYTES is clamped to MAX_BYTES.
- **START**
  - Drives `tx_data` = payload[idx*8+:8] and `tx_data_ready`=1 for exactly one cycle, then goes to GUARD.
- **GUARD**
  - One cycle with `tx_done` ignored. This covers the `uart_tx` latency before it deasserts done. Goes to WAIT.
- **WAIT**
  - Holds until `tx_done`=1.
  - If idx == len-1: pulse `frame_done[grant_id]` and go to IDLE.
  - Otherwise: idx+1, then START.
- **Arbitration (round-robin)**
  - Both valid: grant the requester that was not granted last. `last_grant` resets to 1, so requester 0 wins the first tie.
  - Single valid: grant that requester.
- **Frame atomicity:** a requester that goes valid mid-frame waits for IDLE. There is no preemption.
- Payload and len are sampled only at acceptance. Later changes on the inputs have no effect on the frame in flight.
- `tx_data` holds its last value outside START.

## Timing
- Reset values:
  - state IDLE, idx 0, `last_grant` 1
  - `req_ready` 0 while `rst` is high
  - `frame_done` 0, `tx_data` 0x00, `tx_data_ready` 0, `busy` 0, `grant_id` 0
- Acceptance at cycle N → first `tx_data_ready` at N+1.
- `tx_done` seen in WAIT at cycle M:
  - next byte's `tx_data_ready` at M+1, or
  - `frame_done` at M+1, with IDLE also at M+1.
- A new grant is possible at M+1, which gives one idle cycle between back-to-back frames.
- `busy` is high from N+1 through the cycle `frame_done` is high.
- **Reset mid-frame:** the frame is aborted, with no `frame_done` and no further `tx_data_ready`. A byte already inside `uart_tx` finishes on its own.
- Simultaneous `rst` and `req_valid`: reset wins and nothing is accepted.

## Configuration
- `UART_TX_ARBITER_FIXED_PRIO_EN`
  - Defined: requester 0 always wins when both are valid, and `last_grant` is unused. Command responses are never delayed behind more than one in-flight event frame.
  - Undefined: round-robin as described above.

## Test plan
- Req0 len 3, payload 0x00ABCDEF, uart_tx→uart_rx loopback → rx bytes EF, CD, AB in order; exactly one `frame_done[0]` pulse; `busy` low afterwards.
- Both valid on the same cycle, req0 len 2 = 0xAAAA, req1 len 1 = 0x55 → req0 bytes AA AA, then 55; a second simultaneous pair → req1 is served first. With `UART_TX_ARBITER_FIXED_PRIO_EN` defined → req0 is always served first.
- Req1 asserts valid during req0's 4-byte frame 0x89ABCDEF → rx stream EF CD AB 89 with no interleave, then req1's bytes.
- Req0 len 0 → `req_ready` high for one cycle, `frame_done[0]` on the next cycle, no `tx_data_ready`. Len 7 → exactly 4 bytes sent.
- `rst` pulsed after the 2nd byte of a 4-byte frame → no further `tx_data_ready`, no `frame_done`, all outputs at reset values; the next frame 0x01 (len 1) sends correctly.
- Payload inputs changed after acceptance → bytes sent match the value latched at acceptance.
